// File: rtl/cnn_window_gen_pkg.sv
// Shared defaults, FSM state type and helpers for the stage-2 window generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cnn_window_gen_pkg;

    // Stage-2 feature-map geometry and pixel width used as top-level defaults.
    localparam int ST2_IW       = 12;
    localparam int ST2_IH       = 12;
    localparam int DEF_KX       = 5;
    localparam int DEF_KY       = 5;
    localparam int ST2_CONV_IBW = 8;
    localparam int ST2_WIN_BW   = DEF_KX * DEF_KY * ST2_CONV_IBW;

    // S_FILL while the line buffer still lacks KY-1 rows of this frame.
    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } win_state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// Holds KY-1 rows of IW pixels; column write shifts the column down one row.
// Latency: read is combinational from the addressed column; write lands on the next edge.
// Backpressure: none; a write happens on every cycle the enable is high.
module cnn_line_buffer
    import cnn_window_gen_pkg::*;
#(
    parameter int IW  = ST2_IW,
    parameter int KY  = DEF_KY,
    parameter int IBW = ST2_CONV_IBW
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [cnt_w(IW)-1:0]    i_col,
    input  logic [IBW-1:0]          i_pixel,
    output logic [(KY-1)*IBW-1:0]   o_col
);

    // Row 0 is the previous image row, row KY-2 the oldest one kept.
    logic [IBW-1:0] lb_q [KY-1][IW];
    logic [IBW-1:0] lb_d [KY-1][IW];

    // Shift the addressed column down one row and drop the new pixel into row 0.
    always_comb begin
        lb_d = lb_q;
        if (i_wr_en) begin
            for (int k = KY - 2; k >= 1; k--) begin
                lb_d[k][i_col] = lb_q[k-1][i_col];
            end
            lb_d[0][i_col] = i_pixel;
        end
    end

    // Storage has no reset; stale contents are never observable downstream.
    always_ff @(posedge clk) begin
        lb_q <= lb_d;
    end

    // Combinational read of the addressed column, row k at slice k.
    always_comb begin
        o_col = '0;
        for (int k = 0; k < KY - 1; k++) begin
            o_col[k*IBW +: IBW] = lb_q[k][i_col];
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream in, every fully populated KX x KY window out, packed for cnn_kernel.
// Latency: pixel accepted at edge N gives its window with o_ot_valid high in cycle N+1.
// Backpressure: none; one pixel per i_in_valid cycle, outputs hold while input is idle.
module cnn_window_gen
    import cnn_window_gen_pkg::*;
#(
    parameter int IW  = ST2_IW,
    parameter int IH  = ST2_IH,
    parameter int KX  = DEF_KX,
    parameter int KY  = DEF_KY,
    parameter int IBW = ST2_CONV_IBW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_in_valid,
    input  logic [IBW-1:0]          i_in_pixel,
    output logic                    o_ot_valid,
    output logic [KX*KY*IBW-1:0]    o_ot_fmap,
    output logic                    o_frame_done
);

    localparam int CW = cnt_w(IW);
    localparam int RW = cnt_w(IH);
    localparam int WB = KX * KY * IBW;

    localparam logic [CW-1:0] COL_LAST  = CW'(IW - 1);
    localparam logic [CW-1:0] COL_WIN0  = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IH - 1);
    localparam logic [RW-1:0] ROW_FILLN = RW'(KY - 2);

    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    win_state_t             state_q, state_d;
    logic [WB-1:0]          win_q, win_d;
    logic                   ot_valid_q, ot_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [(KY-1)*IBW-1:0]  lb_col;
    logic [KY*IBW-1:0]      new_col;
    logic                   end_of_row;
    logic                   end_of_frame;

    cnn_line_buffer #(
        .IW  (IW),
        .KY  (KY),
        .IBW (IBW)
    ) u_line_buffer (
        .clk     (clk),
        .i_wr_en (i_in_valid),
        .i_col   (col_q),
        .i_pixel (i_in_pixel),
        .o_col   (lb_col)
    );

    assign end_of_row   = (col_q == COL_LAST);
    assign end_of_frame = end_of_row && (row_q == ROW_LAST);

    // Raster position of the next pixel; wraps straight into the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_in_valid) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Fill/run sequencing: run once KY-1 rows are buffered, refill at each frame start.
    always_comb begin
        state_d = state_q;
        if (i_in_valid) begin
            case (state_q)
                S_FILL: if (end_of_row && (row_q == ROW_FILLN)) state_d = S_RUN;
                S_RUN:  if (end_of_frame)                       state_d = S_FILL;
                default:                                        state_d = S_FILL;
            endcase
        end
    end

    // Column entering the window: oldest buffered row at ky=0, live pixel at ky=KY-1.
    always_comb begin
        new_col = '0;
        for (int ky = 0; ky < KY - 1; ky++) begin
            new_col[ky*IBW +: IBW] = lb_col[(KY-2-ky)*IBW +: IBW];
        end
        new_col[(KY-1)*IBW +: IBW] = i_in_pixel;
    end

    // Window shifts left one column per accepted pixel; new column enters at kx=KX-1.
    always_comb begin
        win_d = win_q;
        if (i_in_valid) begin
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX - 1; kx++) begin
                    win_d[(ky*KX+kx)*IBW +: IBW] = win_q[(ky*KX+kx+1)*IBW +: IBW];
                end
            end
            for (int ky = 0; ky < KY; ky++) begin
                win_d[(ky*KX+KX-1)*IBW +: IBW] = new_col[ky*IBW +: IBW];
            end
        end
    end

    // Emit only when every window column lies inside the current row.
    always_comb begin
        ot_valid_d   = i_in_valid && (state_q == S_RUN) && (col_q >= COL_WIN0);
        frame_done_d = ot_valid_d && end_of_frame;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, window and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            ot_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            ot_valid_q   <= ot_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_ot_valid   = ot_valid_q;
    assign o_ot_fmap    = win_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen with an 8x8 map, 5x5 window, 8-bit pixels.
// Latency: windows checked one cycle after the accept that completes them.
// Backpressure: n/a; input gaps exercised explicitly.
module tb_cnn_window_gen;

    localparam int IW  = 8;
    localparam int IH  = 8;
    localparam int KX  = 5;
    localparam int KY  = 5;
    localparam int IBW = 8;
    localparam int FW  = KX * KY * IBW;
    localparam int NPF = IW * IH;
    localparam int WPF = (IW - KX + 1) * (IH - KY + 1);

    logic           clk;
    logic           rst;
    logic           i_in_valid;
    logic [IBW-1:0] i_in_pixel;
    logic           o_ot_valid;
    logic [FW-1:0]  o_ot_fmap;
    logic           o_frame_done;

    cnn_window_gen #(
        .IW  (IW),
        .IH  (IH),
        .KX  (KX),
        .KY  (KY),
        .IBW (IBW)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .i_in_valid   (i_in_valid),
        .i_in_pixel   (i_in_pixel),
        .o_ot_valid   (o_ot_valid),
        .o_ot_fmap    (o_ot_fmap),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Captured windows: fmap, frame-relative index of the completing pixel, done flag.
    logic [FW-1:0] q_fmap [$];
    int            q_pix  [$];
    bit            q_fd   [$];

    int            acc = 0;
    bit            last_edge_acc = 1'b0;
    bit            gapped = 1'b0;
    bit            prev_valid = 1'b0;
    logic [FW-1:0] prev_fmap = '0;
    int            lat_err = 0;
    int            b2b_err = 0;
    int            stab_err = 0;
    int            fd_stray = 0;

    typedef struct {
        int    scen;
        string name;
        int    kind;   // 0: element value, 1: completing pixel index
        int    win;
        int    el;
        int    exp;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int val, input bit v);
        i_in_valid = v;
        i_in_pixel = IBW'(val);
        @(posedge clk);
        last_edge_acc = v;
        if (v) acc++;
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 1'b0);
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int i = 0; i < NPF; i++) begin
            send(base + i, 1'b1);
            if (gap) send(0, 1'b0);
        end
    endtask

    task automatic clear_q();
        q_fmap.delete();
        q_pix.delete();
        q_fd.delete();
    endtask

    function automatic int elem(input logic [FW-1:0] f, input int i);
        return int'(f[i*IBW +: IBW]);
    endfunction

    // Compare captured windows against the table and an independent raster model.
    task automatic run_checks(input int scen, input int frames, input int base0, input int base1);
        int errs;
        int fd_n;
        int fd_ok;
        int act;
        chk($sformatf("s%0d_win_count", scen), q_pix.size(), frames * WPF);
        fd_n  = 0;
        fd_ok = 0;
        foreach (q_fd[k]) begin
            if (q_fd[k]) begin
                fd_n++;
                if (q_pix[k] == NPF - 1) fd_ok++;
            end
        end
        chk($sformatf("s%0d_frame_done_count", scen), fd_n, frames);
        chk($sformatf("s%0d_frame_done_on_last", scen), fd_ok, frames);
        foreach (tbl[t]) begin
            if (tbl[t].scen == scen) begin
                if (tbl[t].win >= q_pix.size()) act = -1;
                else if (tbl[t].kind == 1) act = q_pix[tbl[t].win];
                else act = elem(q_fmap[tbl[t].win], tbl[t].el);
                chk($sformatf("s%0d_%s", scen, tbl[t].name), act, tbl[t].exp);
            end
        end
        errs = 0;
        foreach (q_pix[k]) begin
            int base;
            int kk;
            int r;
            int c;
            base = (k / WPF == 0) ? base0 : base1;
            kk   = k % WPF;
            r    = (KY - 1) + kk / (IW - KX + 1);
            c    = (KX - 1) + kk % (IW - KX + 1);
            if (q_pix[k] != r * IW + c) errs++;
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    if (elem(q_fmap[k], ky * KX + kx) !=
                        ((base + (r - KY + 1 + ky) * IW + (c - KX + 1 + kx)) & 255)) errs++;
                end
            end
        end
        chk($sformatf("s%0d_model_mismatches", scen), errs, 0);
        chk($sformatf("s%0d_latency_errors", scen), lat_err, 0);
        chk($sformatf("s%0d_stray_frame_done", scen), fd_stray, 0);
    endtask

    // Output monitor, sampling midway between active edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_done && !o_ot_valid) fd_stray++;
            if (o_ot_valid) begin
                if (!last_edge_acc) lat_err++;
                if (gapped && prev_valid) b2b_err++;
                q_fmap.push_back(o_ot_fmap);
                q_pix.push_back((acc - 1) % NPF);
                q_fd.push_back(o_frame_done);
            end
            if (!last_edge_acc && (o_ot_fmap != prev_fmap)) stab_err++;
        end
        prev_fmap  = o_ot_fmap;
        prev_valid = o_ot_valid;
    end

    initial begin
        // scen, name, kind, window, element, expected
        tbl.push_back('{1, "first_pix",     1, 0,  0, 36});
        tbl.push_back('{1, "first_el0",     0, 0,  0, 0});
        tbl.push_back('{1, "first_el12",    0, 0, 12, 18});
        tbl.push_back('{1, "first_el24",    0, 0, 24, 36});
        tbl.push_back('{1, "row5_first",    1, 4,  0, 44});
        tbl.push_back('{1, "row5_el24",     0, 4, 24, 44});
        tbl.push_back('{1, "last_pix",      1, 15, 0, 63});
        tbl.push_back('{1, "last_el0",      0, 15, 0, 27});
        tbl.push_back('{1, "last_el24",     0, 15, 24, 63});
        tbl.push_back('{2, "first_pix",     1, 0,  0, 36});
        tbl.push_back('{2, "first_el12",    0, 0, 12, 18});
        tbl.push_back('{2, "last_el0",      0, 15, 0, 27});
        tbl.push_back('{2, "last_el24",     0, 15, 24, 63});
        tbl.push_back('{3, "f2_first_pix",  1, 16, 0, 36});
        tbl.push_back('{3, "f2_first_el0",  0, 16, 0, 100});
        tbl.push_back('{3, "f2_first_el24", 0, 16, 24, 136});
        tbl.push_back('{3, "f2_last_el24",  0, 31, 24, 163});
        tbl.push_back('{4, "first_pix",     1, 0,  0, 36});
        tbl.push_back('{4, "first_el0",     0, 0,  0, 200});
        tbl.push_back('{4, "first_el24",    0, 0, 24, 236});

        rst        = 1'b1;
        i_in_valid = 1'b0;
        i_in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(o_ot_valid), 0);
        chk("reset_done", int'(o_frame_done), 0);
        chk("reset_fmap_zero", int'(o_ot_fmap == '0), 1);
        rst = 1'b0;
        idle(2);

        // Continuous frame.
        clear_q();
        send_frame(0, 1'b0);
        idle(3);
        run_checks(1, 1, 0, 0);

        // Same frame with an idle cycle after every pixel.
        clear_q();
        gapped = 1'b1;
        send_frame(0, 1'b1);
        idle(3);
        gapped = 1'b0;
        run_checks(2, 1, 0, 0);
        chk("s2_back_to_back_valid", b2b_err, 0);
        chk("s2_fmap_unstable_in_gap", stab_err, 0);

        // Two frames with no idle cycle between them.
        clear_q();
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        idle(3);
        run_checks(3, 2, 0, 100);

        // Reset after pixel 45, then a fresh frame.
        for (int i = 0; i <= 45; i++) send(i, 1'b1);
        rst = 1'b1;
        #1;
        chk("s4_reset_valid", int'(o_ot_valid), 0);
        chk("s4_reset_done", int'(o_frame_done), 0);
        chk("s4_reset_fmap_zero", int'(o_ot_fmap == '0), 1);
        idle(2);
        acc = 0;
        clear_q();
        rst = 1'b0;
        idle(1);
        send_frame(200, 1'b0);
        idle(3);
        run_checks(4, 1, 200, 200);
        chk("s4_stable_when_idle", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cnn_window_gen.md
# cnn_window_gen

Streaming window generator that feeds `cnn_kernel`. It takes one raster-order feature-map pixel per valid cycle, buffers KY-1 rows internally, and emits every fully populated KX×KY window. The window is packed exactly as `cnn_kernel` expects on `i_in_fmap`, with a matching valid strobe. It sits between the stage-1 output (or frame source) and the stage-2 convolution kernel array.

## Interface
- `IW`, default 12: feature-map width in pixels, ≥ KX.
- `IH`, default 12: feature-map height in pixels, ≥ KY.
- `KX`, default `` `KX `` (5): window width.
- `KY`, default `` `KY `` (5): window height.
- `IBW`, default `` `ST2_Conv_IBW ``: pixel bit width.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous reset, active-high.
- `i_in_valid`, input, 1: pixel strobe; one pixel is accepted per high cycle. There is no backpressure.
- `i_in_pixel`, input, IBW: pixel value, raster order (row-major, column 0 first).
- `o_ot_valid`, output, 1: `o_ot_fmap` holds a complete window this cycle.
- `o_ot_fmap`, output, KX*KY*IBW: window; element index `ky*KX+kx` at bits `[idx*IBW +: IBW]`.
- `o_frame_done`, output, 1: single-cycle pulse, coincident with the last window of a frame.

## Operation
- Counters `col` (0..IW-1) and `row` (0..IH-1) track the position of the next pixel. Both advance only on `i_in_valid`.
- `col` wraps to 0 after IW-1, and `row` increments on that wrap. After (IH-1, IW-1), both wrap to 0 and a new frame starts with no idle cycle.
- The line buffer (`cnn_line_buffer`) holds KY-1 rows of IW pixels. `lb[0]` is the previous row and `lb[KY-2]` is the oldest.
- On accepting pixel p at (r,c):
  - Read the column vector {lb[KY-2][c], …, lb[0][c], p}.
  - Write column c shifted down: lb[k+1][c] ← lb[k][c], and lb[0][c] ← p.
- Window register shift, on the same accept:
  - Columns kx=1..KX-1 move to kx-1.
  - The new column vector enters kx=KX-1. Row ky=0 is the oldest row and ky=KY-1 is the current pixel's row.
- Window element (ky,kx) therefore equals pixel(r-KY+1+ky, c-KX+1+kx). Element 0 is the top-left pixel and element KX*KY-1 is the newest pixel.
- State machine, advanced on accept:
  - S_FILL: row < KY-1. No windows are produced. Transitions to S_RUN on the accept of pixel (KY-2, IW-1).
  - S_RUN: rows KY-1..IH-1. A window is emitted when c ≥ KX-1. Returns to S_FILL on the accept of (IH-1, IW-1).
- Windows per frame: (IW-KX+1)*(IH-KY+1). Windows that would straddle a row boundary are never emitted.
- Line-buffer contents are never cleared. Stale data is unreachable because of the state/column gating.

## Timing
- Latency: pixel accepted at edge N gives `o_ot_valid`=1 in cycle N+1 with the window ending at that pixel.
- `o_ot_valid` is high for exactly one cycle per qualifying accept. Back-to-back valid input gives back-to-back windows.
- When `i_in_valid` is low:
  - Counters, line buffer and window register hold.
  - `o_ot_valid` and `o_frame_done` drop to 0.
  - `o_ot_fmap` holds its last value.
- `o_frame_done` is registered and asserts in the same cycle as the `o_ot_valid` for the window at (IH-1, IW-1).
- Reset values: `o_ot_valid`=0, `o_frame_done`=0, `o_ot_fmap`=0, `col`=`row`=0, state S_FILL.
- Reset mid-frame aborts the frame. The next accepted pixel is treated as (0,0), and no window may contain pre-reset pixels before KY-1 full new rows have been accepted.
- Downstream `cnn_kernel` must be driven directly by `o_ot_valid` and `o_ot_fmap`. No extra alignment is needed.

## Structure
- Additions to `defines_cnn_core.v`:
  - `` `ST2_IW `` and `` `ST2_IH `` (stage-2 map size).
  - `` `ST2_WIN_BW `` = `` `KX*`KY*`ST2_Conv_IBW ``.
  - These are the top-level defaults; the module parameters default to them.
- Sub-module `cnn_line_buffer`:
  - Parameters IW, KY, IBW.
  - Ports: `clk`, write enable, column address, input pixel, and a (KY-1)*IBW column read.
  - The read is combinational from the addressed column.
  - Implemented as a register array or distributed RAM.
- Top module contents: counters, state, window shift register, output registers.

## Test plan
Use IW=IH=8, KX=KY=5, IBW=8, and pixel value = r*8+c.
- Continuous frame (64 valid cycles):
  - The first `o_ot_valid` comes one cycle after accepting pixel 36, with element 0 = 0, element 12 = 18 and element 24 = 36.
  - Exactly 16 windows are produced.
  - The last window has element 0 = 27 and element 24 = 63, with `o_frame_done` high on that cycle only.
- Gapped input, `i_in_valid` toggling 1-0-1-0:
  - The same 16 windows and values as the continuous case are produced.
  - `o_ot_fmap` is stable during gaps and `o_ot_valid` is never high two cycles in a row.
- Row-boundary gating: no `o_ot_valid` follows the accepts at c=0..3 of any row. Example: none after pixel 40 (r=5, c=0).
- Two back-to-back frames, the second with value = 100 + r*8 + c:
  - No window in frame 2 before its pixel 36.
  - The first window of frame 2 has element 0 = 100.
- Reset asserted after pixel 45, then a fresh frame (value = 200 + idx):
  - Outputs are 0 during reset.
  - The first window comes after the new pixel 36, with element 0 = 200 and element 24 = 236.
  - No window appears earlier.
